// File: rtl/dmem_master_pkg.sv
// Shared definitions for the data-memory request controller, its memory
// model and benches.
package dmem_master_pkg;

   // state   | meaning
   // IDLE    | ready for a request; request fields are latched on accept
   // ACCESS  | one-cycle memory strobe (we or re) with latched addr/data
   // WAIT    | capture memory q / dmem_error into the response registers
   // RESP    | response valid, held stable until the consumer accepts it
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam int DMEM_DEPTH_DFLT = 1024;

endpackage

// File: rtl/dmem_master_sat_counter.sv
// Saturating up-counter: increments on en_i and sticks at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // next count: hold once saturated
   always_comb begin
      cnt_d = cnt_q;
      if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_master.sv
// Request-side controller for the single-port data memory: one outstanding
// read/write, one-cycle memory strobe, back-pressure tolerant response and
// saturating debug counters.
module dmem_master
   import dmem_master_pkg::*;
#(
   parameter int MEM_DEPTH = DMEM_DEPTH_DFLT,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [63:0]      req_addr,
   input  logic [63:0]      req_wdata,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [63:0]      resp_rdata,
   output logic             resp_error,
   output logic [63:0]      mem_data,
   output logic [63:0]      mem_addr,
   output logic             mem_we,
   output logic             mem_re,
   input  logic [63:0]      mem_q,
   input  logic             mem_error,
   output logic [CNT_W-1:0] cnt_reads,
   output logic [CNT_W-1:0] cnt_writes,
   output logic [CNT_W-1:0] cnt_errors
);

   state_t      state_q, state_d;
   logic        write_q, write_d;
   logic        range_err_q, range_err_d;
   logic [63:0] addr_q, addr_d;
   logic [63:0] wdata_q, wdata_d;
   logic [63:0] rdata_q, rdata_d;
   logic        error_q, error_d;
   logic        addr_oor;
   logic        resp_hs;

   assign addr_oor = (req_addr >= 64'(MEM_DEPTH));

   // next state, response capture and handshake/strobe outputs
   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      range_err_d = range_err_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      error_d     = error_q;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      mem_we      = 1'b0;
      mem_re      = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               write_d     = req_write;
               addr_d      = req_addr;
               wdata_d     = req_wdata;
               range_err_d = addr_oor;
               // An out-of-range request skips the strobe but still spends
               // one cycle in WAIT, so its response appears one cycle after
               // acceptance with the memory untouched.
               state_d     = addr_oor ? WAIT : ACCESS;
            end
         end
         ACCESS: begin
            mem_we  = write_q;
            mem_re  = !write_q;
            state_d = WAIT;
         end
         WAIT: begin
            error_d = range_err_q | mem_error;
            rdata_d = (write_q || range_err_q || mem_error) ? 64'd0 : mem_q;
            state_d = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         write_q     <= 1'b0;
         range_err_q <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         range_err_q <= range_err_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         error_q     <= error_d;
      end
   end

   assign mem_addr   = addr_q;
   assign mem_data   = wdata_q;
   assign resp_rdata = rdata_q;
   assign resp_error = error_q;
   assign resp_hs    = resp_valid && resp_ready;

   sat_counter #(.W(CNT_W)) u_cnt_reads (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (resp_hs && !error_q && !write_q),
      .cnt_o (cnt_reads)
   );

   sat_counter #(.W(CNT_W)) u_cnt_writes (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (resp_hs && !error_q && write_q),
      .cnt_o (cnt_writes)
   );

   sat_counter #(.W(CNT_W)) u_cnt_errors (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (resp_hs && error_q),
      .cnt_o (cnt_errors)
   );

endmodule

// File: tb/tb_dmem_master.sv
// Bench for dmem_master: behavioural memory, reference memory image and a
// response scoreboard. Counters are built 2 bits wide so saturation is reachable.
module tb_dmem_master;
   import dmem_master_pkg::*;

   localparam int DEPTH = DMEM_DEPTH_DFLT;
   localparam int CW    = 2;
   localparam int CMAX  = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [63:0]   req_addr = '0;
   logic [63:0]   req_wdata = '0;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic [63:0]   resp_rdata;
   logic          resp_error;
   logic [63:0]   mem_data;
   logic [63:0]   mem_addr;
   logic          mem_we;
   logic          mem_re;
   logic [63:0]   mem_q = '0;
   logic          mem_error = 1'b0;
   logic [CW-1:0] cnt_reads;
   logic [CW-1:0] cnt_writes;
   logic [CW-1:0] cnt_errors;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_rd = 0, exp_wr = 0, exp_er = 0;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      logic        wr;
      int          lat;
      int          mem_cycles;
   } exp_t;

   exp_t        sb[$];
   logic [63:0] ref_mem [0:DEPTH-1];
   logic [63:0] mem [0:DEPTH-1] = '{default: 64'd0};

   dmem_master #(.MEM_DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_error (resp_error),
      .mem_data   (mem_data),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .mem_q      (mem_q),
      .mem_error  (mem_error),
      .cnt_reads  (cnt_reads),
      .cnt_writes (cnt_writes),
      .cnt_errors (cnt_errors)
   );

   always #5 clk = ~clk;

   // synchronous single-port memory: q registered on the read strobe
   always @(posedge clk) begin
      if (mem_addr < 64'(DEPTH)) begin
         if (mem_we) mem[mem_addr[9:0]] <= mem_data;
         if (mem_re) mem_q <= mem[mem_addr[9:0]];
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_req_ready"},  req_ready,  1);
      check_eq({tag, "_resp_valid"}, resp_valid, 0);
      check_eq({tag, "_resp_rdata"}, resp_rdata, 0);
      check_eq({tag, "_resp_error"}, resp_error, 0);
      check_eq({tag, "_mem_we"},     mem_we,     0);
      check_eq({tag, "_mem_re"},     mem_re,     0);
      check_eq({tag, "_mem_addr"},   mem_addr,   0);
      check_eq({tag, "_mem_data"},   mem_data,   0);
      check_eq({tag, "_cnt_reads"},  cnt_reads,  0);
      check_eq({tag, "_cnt_writes"}, cnt_writes, 0);
      check_eq({tag, "_cnt_errors"}, cnt_errors, 0);
   endtask

   // one full transaction: drive, observe latency/strobes, back-pressure, handshake
   task automatic xact(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                       input int bp, input logic merr);
      exp_t        e;
      exp_t        got;
      int          lat;
      int          mem_cyc;
      bit          seen;
      bit          oor;
      logic [63:0] rd0;
      logic        er0;
      oor          = (addr >= 64'(DEPTH));
      e.wr         = wr;
      e.err        = oor | merr;
      e.rdata      = (wr || e.err) ? 64'd0 : ref_mem[addr[9:0]];
      e.lat        = oor ? 1 : 2;
      e.mem_cycles = oor ? 0 : 1;
      if (wr && !oor) ref_mem[addr[9:0]] = wd;
      sb.push_back(e);

      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = wr;
      req_addr   = addr;
      req_wdata  = wd;
      resp_ready = 1'b0;
      check_eq("req_ready_idle", req_ready, 1);
      @(posedge clk);
      lat = 0; mem_cyc = 0; seen = 0;
      while (lat < 8 && !seen) begin
         @(negedge clk);
         if (lat == 0) begin
            req_valid = 1'b0;
            req_write = ~wr;
            req_addr  = ~addr;
            req_wdata = ~wd;
         end
         mem_error = (lat == 1) ? merr : 1'b0;
         if (mem_we || mem_re) begin
            mem_cyc++;
            check_eq("mem_we",   mem_we,   wr);
            check_eq("mem_re",   mem_re,   !wr);
            check_eq("mem_addr", mem_addr, addr);
            if (wr) check_eq("mem_data", mem_data, wd);
         end
         if (resp_valid) begin
            seen = 1;
         end else begin
            check_eq("req_ready_busy", req_ready, 0);
            @(posedge clk);
            lat++;
         end
      end
      mem_error = 1'b0;
      got = sb.pop_front();
      if (!seen) begin
         check_eq("resp_timeout", 0, 1);
         return;
      end
      rd0 = resp_rdata;
      er0 = resp_error;
      for (int i = 0; i < bp; i++) begin
         @(posedge clk);
         @(negedge clk);
         check_eq("bp_valid",     resp_valid, 1);
         check_eq("bp_rdata",     resp_rdata, rd0);
         check_eq("bp_error",     resp_error, er0);
         check_eq("bp_req_ready", req_ready,  0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      check_eq("latency",      lat,        got.lat);
      check_eq("mem_cycles",   mem_cyc,    got.mem_cycles);
      check_eq("resp_rdata",   rd0,        got.rdata);
      check_eq("resp_error",   er0,        got.err);
      check_eq("resp_dropped", resp_valid, 0);
      check_eq("ready_back",   req_ready,  1);
      if (got.err)      exp_er = (exp_er < CMAX) ? exp_er + 1 : CMAX;
      else if (got.wr)  exp_wr = (exp_wr < CMAX) ? exp_wr + 1 : CMAX;
      else              exp_rd = (exp_rd < CMAX) ? exp_rd + 1 : CMAX;
      check_eq("cnt_reads",  cnt_reads,  exp_rd);
      check_eq("cnt_writes", cnt_writes, exp_wr);
      check_eq("cnt_errors", cnt_errors, exp_er);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 64'd0;
      #1;
      check_reset_vals("rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // write then read
      xact(1'b1, 64'd5, 64'h1234567890ABCDEF, 0, 1'b0);
      xact(1'b0, 64'd5, 64'd0, 0, 1'b0);
      // range boundaries, including a huge unsigned address
      xact(1'b0, 64'd1024, 64'd0, 0, 1'b0);
      xact(1'b0, 64'd1023, 64'd0, 0, 1'b0);
      xact(1'b1, 64'h8000_0000_0000_0005, 64'hFFFF, 0, 1'b0);
      // back-pressure
      xact(1'b1, 64'd20, 64'hA5A5A5A5A5A5A5A5, 0, 1'b0);
      xact(1'b0, 64'd20, 64'd0, 5, 1'b0);
      // memory-reported error on a read
      xact(1'b0, 64'd3, 64'd0, 0, 1'b1);
      xact(1'b0, 64'd5, 64'd0, 2, 1'b0);

      // reset in the middle of ACCESS
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 64'd7; req_wdata = 64'hDEAD_BEEF;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check_eq("mid_access_we", mem_we, 1);
      rst_n = 1'b0;
      #1;
      check_reset_vals("midrst");
      exp_rd = 0; exp_wr = 0; exp_er = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("post_rst_ready",   req_ready,  1);
         check_eq("post_rst_no_resp", resp_valid, 0);
      end

      // counter saturation
      for (int i = 0; i < 5; i++) xact(1'b0, 64'd0, 64'd0, 0, 1'b0);
      repeat (3) @(negedge clk);
      check_eq("sat_hold", cnt_reads, CMAX);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
